// File: rtl/store_unit_if.sv
// Store-unit bus bundle: core-side store handshake, data-memory write
// channel and status flags. The store unit connects through the slave
// modport; the core/memory side (or a bench) connects through master.
interface store_unit_if;
    logic        st_valid;
    logic        st_ready;
    logic        is_sb;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;
    logic        misalign;

    modport master (
        output st_valid, is_sb, st_addr, st_data, mem_ready,
        input  st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, misalign
    );

    modport slave (
        input  st_valid, is_sb, st_addr, st_data, mem_ready,
        output st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, misalign
    );
endinterface

// File: rtl/store_unit.sv
// store_unit: write buffer between the core's sb/sw stores and data memory.
// Stores are lane-encoded on acceptance and queued in a DEPTH-entry FIFO that
// drains to memory strictly in order over a valid/ready channel.
// Optional feature macro: STORE_MISALIGN_TRAP_EN -- when defined, a misaligned
// sw completes its handshake but is dropped and a one-cycle misalign pulse
// follows; when undefined, misalign is tied low and the sw is written with
// its low address bits cleared.
module store_unit #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    store_unit_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_PARTIAL = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    // sb replicates the low byte to every lane; sw passes the word through
    function automatic logic [31:0] lane_data(input logic sb, input logic [31:0] d);
        if (sb) begin
            return {4{d[7:0]}};
        end else begin
            return d;
        end
    endfunction

    // sb enables the single addressed lane; sw enables all four
    function automatic logic [3:0] lane_strb(input logic sb, input logic [1:0] off);
        if (sb) begin
            return 4'b0001 << off;
        end else begin
            return 4'b1111;
        end
    endfunction

    // Pointer advance with explicit wrap at the last entry
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    entry_t           buf_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    buf_state_t       state_r;

    logic             push_s;
    logic             pop_s;
    logic             trap_s;
    logic             enq_s;
    logic [CNT_W-1:0] cnt_next_s;
    buf_state_t       state_next_s;
    entry_t           new_entry_s;
    entry_t           head_s;

    // Handshake decode; readiness comes from registered state only (no pop bypass)
    always_comb begin
        push_s = bus.st_valid && (state_r != BUF_FULL);
        pop_s  = (state_r != BUF_EMPTY) && bus.mem_ready;
`ifdef STORE_MISALIGN_TRAP_EN
        trap_s = push_s && !bus.is_sb && (bus.st_addr[1:0] != 2'b00);
`else
        trap_s = 1'b0;
`endif
        enq_s  = push_s && !trap_s;
    end

    // Lane-encode the presented store into a buffer entry
    always_comb begin
        new_entry_s.addr  = {bus.st_addr[31:2], 2'b00};
        new_entry_s.wdata = lane_data(bus.is_sb, bus.st_data);
        new_entry_s.wstrb = lane_strb(bus.is_sb, bus.st_addr[1:0]);
    end

    // Next occupancy and buffer state; simultaneous push and pop leaves count unchanged
    always_comb begin
        cnt_next_s = count_r;
        case ({enq_s, pop_s})
            2'b10:   cnt_next_s = count_r + CNT_ONE;
            2'b01:   cnt_next_s = count_r - CNT_ONE;
            default: cnt_next_s = count_r;
        endcase
        if (cnt_next_s == CNT_ZERO) begin
            state_next_s = BUF_EMPTY;
        end else if (cnt_next_s == CNT_FULL) begin
            state_next_s = BUF_FULL;
        end else begin
            state_next_s = BUF_PARTIAL;
        end
    end

    // FIFO storage, pointers, count and buffer state; reset discards all entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= '0;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            state_r  <= BUF_EMPTY;
        end else begin
            count_r <= cnt_next_s;
            state_r <= state_next_s;
            if (enq_s) begin
                buf_r[wr_ptr_r] <= new_entry_s;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic misalign_r;

    // One-cycle error pulse following a dropped misaligned sw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= trap_s;
        end
    end

    assign bus.misalign = misalign_r;
`else
    assign bus.misalign = 1'b0;
`endif

    // Head entry drives the memory channel; zeros while empty so reset shows clean outputs
    always_comb begin
        head_s = buf_r[rd_ptr_r];
        if (state_r != BUF_EMPTY) begin
            bus.mem_addr  = head_s.addr;
            bus.mem_wdata = head_s.wdata;
            bus.mem_wstrb = head_s.wstrb;
        end else begin
            bus.mem_addr  = 32'h0000_0000;
            bus.mem_wdata = 32'h0000_0000;
            bus.mem_wstrb = 4'b0000;
        end
    end

    assign bus.st_ready  = (state_r != BUF_FULL);
    assign bus.mem_valid = (state_r != BUF_EMPTY);
    assign bus.busy      = (state_r != BUF_EMPTY);

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit (DEPTH = 2) with a write scoreboard: every
// driven store pushes its expected memory write; the monitor pops and
// compares on each accepted memory write.
module tb_store_unit;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];

    store_unit_if bus();

    store_unit #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one store and hold it until accepted (bounded)
    task automatic do_store(input logic sb, input logic [31:0] a, input logic [31:0] d);
        logic trap;
        logic got;
        int   waited;
        exp_t e;
        bus.st_valid = 1'b1;
        bus.is_sb    = sb;
        bus.st_addr  = a;
        bus.st_data  = d;
        trap = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        trap = !sb && (a[1:0] != 2'b00);
`endif
        if (!trap) begin
            e.a = {a[31:2], 2'b00};
            e.d = sb ? {4{d[7:0]}} : d;
            e.s = sb ? (4'b0001 << a[1:0]) : 4'b1111;
            sb_q.push_back(e);
        end
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 50) begin
            @(negedge clk);
            got = bus.st_ready;
            waited++;
        end
        check("st_ready_wait", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare every accepted memory write against the queue head
    always @(negedge clk) begin
        if (rst_n && bus.mem_valid && bus.mem_ready) begin
            check("write_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_addr",  bus.mem_addr,  e.a);
                check("sb_wdata", bus.mem_wdata, e.d);
                check("sb_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, e.s});
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.st_valid = 1'b0;
        bus.is_sb    = 1'b0;
        bus.st_addr  = 32'h0;
        bus.st_data  = 32'h0;
        bus.mem_ready = 1'b0;

        // Reset state
        #2;
        check("rst_st_ready",  {31'd0, bus.st_ready},  32'd1);
        check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_mem_addr",  bus.mem_addr,           32'h0);
        check("rst_mem_wdata", bus.mem_wdata,          32'h0);
        check("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
        check("rst_misalign",  {31'd0, bus.misalign},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // sb to byte 3: one-cycle latency, replicated data, top lane strobe
        bus.mem_ready = 1'b1;
        do_store(1'b1, 32'h0000_1003, 32'hAABB_CC5A);
        check("sb_latency_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("sb_mem_addr",      bus.mem_addr,           32'h0000_1000);
        check("sb_mem_wdata",     bus.mem_wdata,          32'h5A5A_5A5A);
        check("sb_mem_wstrb",     {28'd0, bus.mem_wstrb}, 32'h8);
        @(posedge clk);
        #1;
        check("sb_drained_busy",  {31'd0, bus.busy},      32'd0);

        // sw held under backpressure for 3 cycles, then a single pop
        bus.mem_ready = 1'b0;
        do_store(1'b0, 32'h0000_2000, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bus.mem_valid}, 32'd1);
            check("hold_addr",  bus.mem_addr,           32'h0000_2000);
            check("hold_wdata", bus.mem_wdata,          32'h1234_5678);
            check("hold_wstrb", {28'd0, bus.mem_wstrb}, 32'hF);
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_busy_after_pop", {31'd0, bus.busy}, 32'd0);

        // Fill to DEPTH with memory stalled
        bus.mem_ready = 1'b0;
        do_store(1'b0, 32'h0000_0100, 32'h1111_1111);
        do_store(1'b1, 32'h0000_0105, 32'h0000_0022);
        check("full_st_ready", {31'd0, bus.st_ready}, 32'd0);
        check("full_head_addr", bus.mem_addr, 32'h0000_0100);
        // Full buffer with st_valid and mem_ready together: pop only
        bus.st_valid  = 1'b1;
        bus.is_sb     = 1'b0;
        bus.st_addr   = 32'h0000_0108;
        bus.st_data   = 32'h3333_3333;
        bus.mem_ready = 1'b1;
        sb_q.push_back('{a: 32'h0000_0108, d: 32'h3333_3333, s: 4'hF});
        @(negedge clk);
        check("no_pop_bypass", {31'd0, bus.st_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        check("after_pop_head", bus.mem_addr, 32'h0000_0104);
        check("after_pop_ready", {31'd0, bus.st_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
        check("refill_full", {31'd0, bus.st_ready}, 32'd0);
        check("refill_head_wstrb", {28'd0, bus.mem_wstrb}, 32'h2);
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("order_drained_busy", {31'd0, bus.busy}, 32'd0);

        // Every byte lane of sb
        for (int i = 0; i < 4; i++) begin
            do_store(1'b1, 32'h0000_4000 + 32'(i), 32'h0000_0090 + 32'(i));
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with two entries buffered
        bus.mem_ready = 1'b0;
        do_store(1'b0, 32'h0000_5000, 32'h5555_0000);
        do_store(1'b0, 32'h0000_5004, 32'h5555_0004);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("arst_busy",      {31'd0, bus.busy},      32'd0);
        check("arst_st_ready",  {31'd0, bus.st_ready},  32'd1);
        check("arst_mem_addr",  bus.mem_addr,           32'h0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_write", {31'd0, bus.mem_valid}, 32'd0);

        // Misaligned sw
        do_store(1'b0, 32'h0000_3002, 32'hCAFE_F00D);
`ifdef STORE_MISALIGN_TRAP_EN
        check("mis_pulse",     {31'd0, bus.misalign},  32'd1);
        check("mis_no_write",  {31'd0, bus.mem_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("mis_pulse_end", {31'd0, bus.misalign},  32'd0);
`else
        check("mis_tied_low",  {31'd0, bus.misalign},  32'd0);
        check("mis_valid",     {31'd0, bus.mem_valid}, 32'd1);
        check("mis_addr",      bus.mem_addr,           32'h0000_3000);
        check("mis_wstrb",     {28'd0, bus.mem_wstrb}, 32'hF);
`endif

        // Everything expected must have been written
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("scoreboard_empty", sb_q.size(), 32'd0);
        check("final_idle", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of write-buffer entries (power of two, minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port st_valid, input, 1 bit: the core presents a store.
REQ-005 SHALL have port st_ready, output, 1 bit: the unit accepts the store this cycle.
REQ-006 SHALL have port is_sb, input, 1 bit: 1 selects sb, 0 selects sw.
REQ-007 SHALL have port st_addr, input, 32 bits: the byte address (the ALU result).
REQ-008 SHALL have port st_data, input, 32 bits: the rs2 value.
REQ-009 SHALL have port mem_valid, output, 1 bit: a write request is pending to data memory.
REQ-010 SHALL have port mem_ready, input, 1 bit: memory accepts the write.
REQ-011 SHALL have port mem_addr, output, 32 bits: the word-aligned address, with bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata, output, 32 bits: the lane-aligned write data.
REQ-013 SHALL have port mem_wstrb, output, 4 bits: the byte-lane enables, bit i covering wdata[8i+7:8i].
REQ-014 SHALL have port busy, output, 1 bit: the buffer is non-empty; the core stalls loads while it is high.
REQ-015 SHALL have port misalign, output, 1 bit: misaligned-store error pulse.

Function
REQ-016 SHALL treat a store as accepted only on a clock edge where st_valid and st_ready are both 1.
REQ-017 SHALL drive st_ready = (count != DEPTH), based on the registered count only, with no same-cycle pop bypass.
REQ-018 SHALL encode an accepted sb as wdata = four copies of st_data[7:0] and wstrb = 1 << st_addr[1:0].
REQ-019 SHALL encode an accepted sw as wdata = st_data and wstrb = 4'hF.
REQ-020 SHALL set the entry address to {st_addr[31:2], 2'b00} for both store types.
REQ-021 SHALL store accepted stores in a FIFO, drained strictly in acceptance order.
REQ-022 SHALL drive mem_valid = (count != 0), with mem_addr, mem_wdata and mem_wstrb taken from the head entry.
REQ-023 SHALL give a latency of 1 cycle: a store accepted at edge N into an empty buffer shows mem_valid = 1 after edge N.
REQ-024 SHALL pop the head on an edge where mem_valid and mem_ready are both 1.
REQ-025 SHALL hold mem_* stable while mem_valid = 1 and mem_ready = 0.
REQ-026 SHALL handle a push and pop on the same edge as: count unchanged, both pointers advance.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL count stores with a counter 0..DEPTH that never overflows or underflows, and SHALL ignore mem_ready while empty.
REQ-029 SHALL define buffer states EMPTY (count = 0), PARTIAL and FULL (count = DEPTH), with transitions only via push/pop per REQ-016, REQ-024 and REQ-026.
REQ-030 SHALL drive busy = mem_valid.

Reset
REQ-031 SHALL, while rst_n = 0, immediately clear count, both pointers and misalign.
REQ-032 SHALL, during reset, drive outputs as follows: st_ready = 1, mem_valid = 0, busy = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
REQ-033 SHALL discard buffered stores on reset mid-operation, with no write issued after reset asserts.

Configuration
REQ-034 SHALL, when STORE_MISALIGN_TRAP_EN is defined, complete the handshake for an accepted sw with st_addr[1:0] != 0 but not enqueue it, and pulse misalign = 1 for exactly the following cycle.
REQ-035 SHALL, when STORE_MISALIGN_TRAP_EN is undefined, tie misalign to 0 and enqueue a misaligned sw per REQ-019 and REQ-020, dropping the low address bits.

Verification
REQ-036 SHALL cover: sb with st_addr = 0x1003 and st_data = 0xAABBCC5A -> mem_addr = 0x1000, wdata = 0x5A5A5A5A, wstrb = 4'b1000.
REQ-037 SHALL cover: sw with st_addr = 0x2000 and st_data = 0x12345678, mem_ready = 0 for 3 cycles -> mem_* stable for 3 cycles, then one pop, then busy = 0.
REQ-038 SHALL cover: 3 back-to-back stores with DEPTH = 2 and mem_ready = 0 -> st_ready = 0 after the 2nd accept; with mem_ready = 1, drained in order.
REQ-039 SHALL cover: full buffer, st_valid = 1 and mem_ready = 1 on the same cycle -> pop only; the push is accepted the next cycle and count stays at 2.
REQ-040 SHALL cover: rst_n driven low asynchronously mid-cycle with 2 entries buffered -> mem_valid = 0 immediately, and no writes after release.
REQ-041 SHALL cover: sw with st_addr = 0x3002 -> with STORE_MISALIGN_TRAP_EN, a misalign pulse and no write; without it, a write to 0x3000 with wstrb = 4'hF.
